// File: rtl/axis_read_addr.sv
// axis_read_addr
//   Read-address front end of the AXI read path. Accepts one job (byte
//   start address + length in stream words), arms the downstream data stage
//   by forwarding the word length, then issues AXI4 INCR read-address bursts.
//   Each burst is limited to BURST_MAX beats and never crosses a 4 KiB page.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   cfg_*               job input handshake (address, length in words)
//   data_cfg_*          word-length forward to axis_read_data
//   axi_ar*             AXI4 read-address channel
module axis_read_addr #(
    parameter int CONFIG_AWIDTH  = 32,
    parameter int CONFIG_DWIDTH  = 32,
    parameter int WIDTH_RATIO    = 8,
    parameter int AXI_DATA_WIDTH = 256,
    parameter int BURST_MAX      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CONFIG_AWIDTH-1:0] cfg_address,
    input  logic [CONFIG_DWIDTH-1:0] cfg_length,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    output logic [CONFIG_DWIDTH-1:0] data_cfg_length,
    output logic                     data_cfg_valid,
    input  logic                     data_cfg_ready,
    output logic [CONFIG_AWIDTH-1:0] axi_araddr,
    output logic [7:0]               axi_arlen,
    output logic [2:0]               axi_arsize,
    output logic [1:0]               axi_arburst,
    output logic                     axi_arvalid,
    input  logic                     axi_arready
);

    localparam int BYTES      = AXI_DATA_WIDTH / 8;
    localparam int LOG2B      = $clog2(BYTES);
    localparam int LOG2R      = $clog2(WIDTH_RATIO);
    localparam int BW         = CONFIG_DWIDTH + 1;
    localparam int PAGE_BEATS = 4096 / BYTES;

    typedef enum logic [1:0] {IDLE, FWD, CALC, ADDR} state_t;

    state_t                   state_reg, state_next;
    logic [CONFIG_AWIDTH-1:0] addr_reg, addr_next;
    logic [CONFIG_AWIDTH-1:0] araddr_reg, araddr_next;
    logic [BW-1:0]            beats_reg, beats_next;
    logic [CONFIG_DWIDTH-1:0] len_reg, len_next;
    logic [8:0]               n_reg, n_next;
    logic [7:0]               arlen_reg, arlen_next;
    logic                     cfg_ready_reg, cfg_ready_next;
    logic                     data_cfg_valid_reg, data_cfg_valid_next;
    logic                     arvalid_reg, arvalid_next;

    logic [BW-1:0]            beats_cfg;
    logic [12:0]              to4k;
    logic [BW-1:0]            n_calc;

    // Arithmetic helpers: beat count of the incoming job and the size of the
    // next burst from the current address/remaining beats.
    always_comb begin
        // One extra bit so a length near 2^CONFIG_DWIDTH does not wrap on round-up.
        beats_cfg = ({1'b0, cfg_length} + BW'(WIDTH_RATIO - 1)) >> LOG2R;
        // Beats left before the next 4 KiB page; a page-aligned address gives a full page.
        to4k      = 13'(PAGE_BEATS) - 13'(addr_reg[11:LOG2B]);
        n_calc    = beats_reg;
        if (n_calc > BW'(BURST_MAX)) begin
            n_calc = BW'(BURST_MAX);
        end
        if (n_calc > BW'(to4k)) begin
            n_calc = BW'(to4k);
        end
    end

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        araddr_next = araddr_reg;
        beats_next  = beats_reg;
        len_next    = len_reg;
        n_next      = n_reg;
        arlen_next  = arlen_reg;

        case (state_reg)
            IDLE: begin
                if (cfg_valid && cfg_ready_reg) begin
                    addr_next  = cfg_address;
                    beats_next = beats_cfg;
                    len_next   = cfg_length;
                    if (cfg_length != '0) begin
                        state_next = FWD;
                    end
                end
            end
            FWD: begin
                if (data_cfg_ready) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                araddr_next = addr_reg;
                arlen_next  = 8'(n_calc - BW'(1));
                n_next      = 9'(n_calc);
                state_next  = ADDR;
            end
            ADDR: begin
                if (axi_arready) begin
                    addr_next  = addr_reg + (CONFIG_AWIDTH'(n_reg) << LOG2B);
                    beats_next = beats_reg - BW'(n_reg);
                    state_next = (beats_next == '0) ? IDLE : CALC;
                end
            end
            default: state_next = IDLE;
        endcase

        // Handshake outputs are registered copies of the next state.
        cfg_ready_next      = (state_next == IDLE);
        data_cfg_valid_next = (state_next == FWD);
        arvalid_next        = (state_next == ADDR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            addr_reg           <= '0;
            araddr_reg         <= '0;
            beats_reg          <= '0;
            len_reg            <= '0;
            n_reg              <= '0;
            arlen_reg          <= '0;
            cfg_ready_reg      <= 1'b0;
            data_cfg_valid_reg <= 1'b0;
            arvalid_reg        <= 1'b0;
        end else begin
            state_reg          <= state_next;
            addr_reg           <= addr_next;
            araddr_reg         <= araddr_next;
            beats_reg          <= beats_next;
            len_reg            <= len_next;
            n_reg              <= n_next;
            arlen_reg          <= arlen_next;
            cfg_ready_reg      <= cfg_ready_next;
            data_cfg_valid_reg <= data_cfg_valid_next;
            arvalid_reg        <= arvalid_next;
        end
    end

    assign cfg_ready       = cfg_ready_reg;
    assign data_cfg_length = len_reg;
    assign data_cfg_valid  = data_cfg_valid_reg;
    assign axi_araddr      = araddr_reg;
    assign axi_arlen       = arlen_reg;
    assign axi_arsize      = 3'(LOG2B);
    assign axi_arburst     = 2'b01;
    assign axi_arvalid     = arvalid_reg;

endmodule

// File: doc/axis_read_addr.md
Name: axis_read_addr

Overview:
- Upstream companion of `axis_read_data` on the AXI read path.
- Accepts one read job: a byte start address plus a length in `DATA_WIDTH` stream words.
- Arms `axis_read_data` by forwarding the word length over a config handshake.
- Issues the matching AXI4 INCR read-address bursts, limited to `BURST_MAX` beats and never crossing a 4 KiB boundary.

Parameters:
- `CONFIG_AWIDTH`, 32, width of the address config and of `axi_araddr`
- `CONFIG_DWIDTH`, 32, width of the length config (stream words)
- `WIDTH_RATIO`, 8, stream words per AXI beat; must be a power of 2
- `AXI_DATA_WIDTH`, 256, AXI data bus width; sets `axi_arsize` and the beat byte size B = `AXI_DATA_WIDTH`/8
- `BURST_MAX`, 16, maximum beats per burst (1..256)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `cfg_address`  in  `CONFIG_AWIDTH`  byte start address; must be B-aligned
- `cfg_length`  in  `CONFIG_DWIDTH`  job length in stream words
- `cfg_valid`  in  1  job valid
- `cfg_ready`  out  1  job accept
- `data_cfg_length`  out  `CONFIG_DWIDTH`  word length forwarded to `axis_read_data`
- `data_cfg_valid`  out  1  forward valid
- `data_cfg_ready`  in  1  forward accept
- `axi_araddr`  out  `CONFIG_AWIDTH`  burst start address
- `axi_arlen`  out  8  beats minus 1
- `axi_arsize`  out  3  constant log2(B)
- `axi_arburst`  out  2  constant 2'b01 (INCR)
- `axi_arvalid`  out  1  AR valid
- `axi_arready`  in  1  AR accept

Behaviour:
- Reset: synchronous, active-high, one clock, one reset. While `rst` is high all registered outputs are 0, including `cfg_ready`, `data_cfg_valid`, `axi_arvalid`, `axi_araddr`, `axi_arlen` and `data_cfg_length`. `rst` asserted in any state aborts the job; any pending AR is dropped.
- State machine: `IDLE`, `FWD`, `CALC`, `ADDR`.
- `IDLE`:
  - `cfg_ready`=1 from the first cycle after `rst` deasserts; it is registered and equals (state==`IDLE`).
  - On `cfg_valid`&`cfg_ready`, latch the address and the beat count `beats` = ceil(`cfg_length`/`WIDTH_RATIO`), computed with `CONFIG_DWIDTH`+1-bit intermediate math.
  - If `cfg_length`==0: stay in `IDLE`. No forward, no AR.
  - Otherwise go to `FWD`.
- `FWD`:
  - `data_cfg_valid`=1, `data_cfg_length`=latched `cfg_length`, held stable until `data_cfg_ready`.
  - On the handshake go to `CALC`. No AR is issued before the data stage is armed.
- `CALC` (exactly one cycle):
  - `to4k` = 4096/B − `addr`[11:log2(B)].
  - `n` = min(`beats`, `BURST_MAX`, `to4k`).
  - Register `axi_araddr`=`addr`, `axi_arlen`=`n`−1.
  - Go to `ADDR`.
- `ADDR`:
  - `axi_arvalid`=1. `axi_araddr`/`axi_arlen` are stable until `axi_arready`; `arvalid` never drops without a handshake.
  - On the handshake: `addr` += `n`·B (modulo 2^`CONFIG_AWIDTH`) and `beats` −= `n`.
  - If `beats` reaches 0, go to `IDLE` with `arvalid` low the next cycle; otherwise go to `CALC`.
- Latency, with `data_cfg_ready` and `axi_arready` tied high:
  - Job accepted at edge k → `data_cfg_valid` in cycle k+1 → first `axi_arvalid` in cycle k+3.
  - Each following burst has a 1-cycle `CALC` gap.
  - `cfg_ready` returns in the cycle after the last AR handshake.
- Boundaries:
  - A partial final beat counts as a full beat (e.g. length 10, ratio 8 → 2 beats).
  - An address exactly on a 4 KiB boundary gives `to4k`=4096/B.
  - `cfg_valid` outside `IDLE` is ignored, not queued.
  - A misaligned `cfg_address` is a caller error; the low log2(B) bits pass through to `axi_araddr` unchanged.

Test Plan:
1. Address 0x1000, length 10 → `data_cfg_length`=10; one AR, `araddr`=0x1000, `arlen`=1, `arsize`=5, `arburst`=01; `cfg_ready` high again afterwards.
2. Address 0x0, length 4096 words (512 beats), `BURST_MAX`=16 → 32 ARs, `arlen`=15 each, addresses 0x0, 0x200, …, 0x3E00; 1-cycle gap between ARs.
3. 4 KiB split: address 0xF80, length 64 (8 beats) → AR 0xF80/`arlen`=3, then AR 0x1000/`arlen`=3.
4. Backpressure: hold `data_cfg_ready`=0 for 5 cycles → no `arvalid` until the handshake. Then hold `axi_arready`=0 for 4 cycles → `araddr`/`arlen` stable and `arvalid` steady; no extra bursts.
5. Length 0, and `cfg_valid` pulsed mid-job → the zero job produces no forward and no AR; the mid-job pulse is not accepted and AR totals match the original job only.
6. Reset while in `ADDR` with `arvalid` high → in the next cycle all outputs are 0. After reset, a new job (address 0x40, length 8) gives a single AR, `arlen`=0.
